motoro3_ramp_ctrl: RTL
======================

Name: motoro3_ramp_ctrl

Overview:
Speed-profile controller for the 3-phase commutation state machine. It issues the start pulse and drives the step-period word m3freq, where a larger value means a slower step and the step period is m3freq×64 clocks. It ramps m3freq from a launch value to a commanded target, one increment per N commutation steps, and ramps back down on stop. It also watches the commutation step stream for stalls and illegal steps, gates the bridge enables, and counts electrical revolutions.

Parameters:
ACCEL_STEPS, 6, commutation-step advances between successive m3freq updates (1..63)
RAMP_INC, 4, m3freq change per update (1..1023)
WDOG_CYC, 131072, clocks without a step advance before stall fault (must exceed 1023×64)
KICK_TMO, 8, clocks allowed after m3start pulse for m3step to become 1

Ports:
clk  input  1  10 MHz; all flops on falling edge, same as commutation block
nRst  input  1  reset, asynchronous, active-low
cmd_run  input  1  level; 1 = run motor, 0 = stop
fault_clr  input  1  single-cycle pulse; clears FAULT only when cmd_run=0
start_freq  input  10  launch/stop m3freq; latched on leaving IDLE
target_freq  input  10  commanded m3freq; sampled every cycle; 0 treated as 1
m3step  input  4  current commutation step from motor state machine
m3start  output  1  start pulse to motor state machine
m3freq  output  10  step-period word to motor state machine
drive_en  output  1  bridge enable; downstream ANDs with aE/bE/cE
at_speed  output  1  1 while in RUN
fault  output  1  1 while in FAULT
rev_cnt  output  16  electrical revolutions since last start, saturating
state  output  3  IDLE=0, KICK=1, RAMP=2, RUN=3, STOPPING=4, FAULT=5

Behaviour:
- Reset values: state=IDLE, m3start=0, m3freq=0, drive_en=0, at_speed=0, fault=0, rev_cnt=0, internal counters=0. Reset is honoured in any state, mid-ramp included, and returns immediately to these values.
- Step advance: registered copy m3step_d. An advance occurs when m3step≠m3step_d and m3step∈1..6. Each advance clears the watchdog counter and increments the step-divider counter.
- Revolution: an advance from 6 to 1 increments rev_cnt, saturating at 0xFFFF. rev_cnt clears on the IDLE→KICK transition.
- Target: tgt = (target_freq==0) ? 1 : target_freq.
- IDLE: drive_en=0, m3start=0.
  - cmd_run=1 → KICK. On the transition, latch sf=start_freq, set m3freq=sf, clear counters.
- KICK: m3start=1 for exactly the first KICK cycle, then 0. drive_en=1.
  - m3step==1 within KICK_TMO clocks → RAMP.
  - Timeout → FAULT.
  - cmd_run=0 → STOPPING.
- RAMP: on each ACCEL_STEPS-th advance (divider then clears), move m3freq toward tgt by RAMP_INC.
  - Use 11-bit arithmetic. If |m3freq−tgt| ≤ RAMP_INC, set m3freq=tgt; no wrap below 1 or above 1023.
  - m3freq==tgt → RUN on the next cycle.
  - cmd_run=0 → STOPPING. This takes priority over an update in the same cycle.
- RUN: at_speed=1, m3freq held.
  - tgt≠m3freq → RAMP, and at_speed drops the same cycle.
  - cmd_run=0 → STOPPING.
- STOPPING: as RAMP, but the destination is sf.
  - m3freq==sf → IDLE, with drive_en=0 from that cycle.
  - cmd_run=1 → RAMP; ramping resumes from the current m3freq.
- Watchdog: active in RAMP, RUN and STOPPING. It counts clocks since the last advance; reaching WDOG_CYC → FAULT.
- Illegal step: in RAMP, RUN or STOPPING, m3step ∉ 1..6 for one sampled cycle → FAULT.
- FAULT: drive_en=0, m3start=0, fault=1, m3freq held at its last value.
  - fault_clr=1 with cmd_run=0 → IDLE.
  - fault_clr while cmd_run=1 is ignored.
- Simultaneous events: fault detection has priority over cmd_run changes, and cmd_run changes have priority over ramp updates.
- m3start is never high in two consecutive cycles. At least one low cycle (IDLE) always precedes a re-kick, so the motor block's edge detector always fires.

Test Plan:
1. Start ramp: start_freq=100, target=80, RAMP_INC=4, ACCEL_STEPS=6, cmd_run↑ → one-cycle m3start; m3freq 100→96 after 6 advances, …→80 after 30 advances; then at_speed=1, state=3.
2. Non-multiple landing: start=100, target=90 → m3freq 96, 92, then 90; RUN entered.
3. Stop: in RUN at 80, cmd_run↓ → STOPPING; m3freq climbs by 4 per 6 advances to 100; then state=0, drive_en=0. rev_cnt equals the number of 6→1 advances seen.
4. Stall: freeze m3step at 3 in RUN → fault=1 exactly WDOG_CYC clocks after the last advance; drive_en=0. fault_clr with cmd_run=1 is ignored; with cmd_run=0 → IDLE.
5. Kick timeout and illegal step: hold m3step=0 after kick → FAULT after 8 clocks. Separately, force m3step=7 in RUN → FAULT next cycle.
6. Mid-ramp events: target 80→120 during RAMP → m3freq reverses direction. cmd_run↓ then ↑ during STOPPING → resumes RAMP from the current m3freq. nRst low mid-ramp → all outputs return to reset values.

Source files
------------

// File: rtl/motoro3_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motoro3_ramp_ctrl
// Speed-profile controller for the 3-phase commutation state machine.
// Kicks the motor block with a one-cycle start pulse, then ramps the
// step-period word m3freq (larger = slower, period = m3freq*64 clocks) from
// the launch value toward the commanded target, one RAMP_INC move every
// ACCEL_STEPS commutation-step advances. On stop it ramps back to the launch
// value before dropping the bridge enable. Stalls (no advance for WDOG_CYC
// clocks), kick timeouts and illegal step codes latch FAULT.
//
// Ports
//   clk          10 MHz clock; every flop runs on the falling edge
//   nRst         asynchronous active-low reset
//   cmd_run      level: 1 = run, 0 = stop
//   fault_clr    pulse: leaves FAULT only while cmd_run = 0
//   start_freq   launch/stop m3freq, latched when leaving IDLE
//   target_freq  commanded m3freq, 0 is treated as 1
//   m3step       current commutation step (legal codes 1..6)
//   m3start      one-cycle start pulse to the motor block
//   m3freq       step-period word to the motor block
//   drive_en     bridge enable
//   at_speed     high while in RUN
//   fault        high while in FAULT
//   rev_cnt      saturating count of 6->1 advances since the last start
//   state        IDLE=0 KICK=1 RAMP=2 RUN=3 STOPPING=4 FAULT=5
// -----------------------------------------------------------------------------
module motoro3_ramp_ctrl #(
  parameter int ACCEL_STEPS = 6,
  parameter int RAMP_INC    = 4,
  parameter int WDOG_CYC    = 131072,
  parameter int KICK_TMO    = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        cmd_run,
  input  logic        fault_clr,
  input  logic [9:0]  start_freq,
  input  logic [9:0]  target_freq,
  input  logic [3:0]  m3step,
  output logic        m3start,
  output logic [9:0]  m3freq,
  output logic        drive_en,
  output logic        at_speed,
  output logic        fault,
  output logic [15:0] rev_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KICK  = 3'd1,
    S_RAMP  = 3'd2,
    S_RUN   = 3'd3,
    S_STOP  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int WD_W = $clog2(WDOG_CYC);
  localparam int KW   = $clog2(KICK_TMO + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG_CYC - 1);
  localparam logic [KW-1:0]   KICK_LAST = KW'(KICK_TMO - 1);
  localparam logic [5:0]      DIV_LAST  = 6'(ACCEL_STEPS - 1);
  localparam logic [10:0]     INC       = 11'(RAMP_INC);

  state_t            state_q, state_d;
  logic [3:0]        step_q;
  logic [9:0]        freq_q, freq_d;
  logic [9:0]        sf_q, sf_d;
  logic [5:0]        div_q, div_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [KW-1:0]     kick_q, kick_d;
  logic [15:0]       rev_q, rev_d;
  logic              m3start_q, drive_en_q, at_speed_q, fault_q;

  logic              legal_s, adv_s, wrap_s, watched_s, watched_d_s;
  logic              flt_s, div_hit_s, ramp_go_s;
  logic              ramping_q_s, ramping_d_s;
  logic [9:0]        tgt_s, ramp_dst_s;

  // One RAMP_INC move toward dst in 11-bit arithmetic; snaps onto dst when
  // within one increment, so the result never crosses dst and never wraps.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] dst);
    logic [10:0] c, d, diff, res;
    c = {1'b0, cur};
    d = {1'b0, dst};
    if (c > d) begin
      diff = c - d;
      res  = (diff <= INC) ? d : (c - INC);
    end else begin
      diff = d - c;
      res  = (diff <= INC) ? d : (c + INC);
    end
    return res[9:0];
  endfunction

  assign legal_s     = (m3step >= 4'd1) && (m3step <= 4'd6);
  assign adv_s       = legal_s && (m3step != step_q);
  assign wrap_s      = adv_s && (step_q == 4'd6) && (m3step == 4'd1);
  assign tgt_s       = (target_freq == 10'd0) ? 10'd1 : target_freq;
  assign watched_s   = state_q inside {S_RAMP, S_RUN, S_STOP};
  assign watched_d_s = state_d inside {S_RAMP, S_RUN, S_STOP};
  assign ramping_q_s = state_q inside {S_RAMP, S_STOP};
  assign ramping_d_s = state_d inside {S_RAMP, S_STOP};
  // Stall: the counter is about to reach WDOG_CYC with no advance this cycle.
  assign flt_s       = watched_s && (!legal_s || (!adv_s && (wdog_q == WD_LAST)));
  assign div_hit_s   = adv_s && (div_q == DIV_LAST);

  // Next-state selection; faults beat cmd_run, cmd_run beats ramp progress.
  always_comb begin
    state_d    = state_q;
    ramp_go_s  = 1'b0;
    ramp_dst_s = tgt_s;
    case (state_q)
      S_IDLE: begin
        if (cmd_run) state_d = S_KICK;
        else         state_d = S_IDLE;
      end
      S_KICK: begin
        if ((m3step != 4'd1) && (kick_q == KICK_LAST)) state_d = S_FAULT;
        else if (!cmd_run)                              state_d = S_STOP;
        else if (m3step == 4'd1)                        state_d = S_RAMP;
        else                                            state_d = S_KICK;
      end
      S_RAMP: begin
        if (flt_s)                 state_d = S_FAULT;
        else if (!cmd_run)         state_d = S_STOP;
        else if (freq_q == tgt_s)  state_d = S_RUN;
        else begin
          state_d   = S_RAMP;
          ramp_go_s = 1'b1;
        end
      end
      S_RUN: begin
        if (flt_s)                 state_d = S_FAULT;
        else if (!cmd_run)         state_d = S_STOP;
        else if (freq_q != tgt_s)  state_d = S_RAMP;
        else                       state_d = S_RUN;
      end
      S_STOP: begin
        ramp_dst_s = sf_q;
        if (flt_s)                 state_d = S_FAULT;
        else if (cmd_run)          state_d = S_RAMP;
        else if (freq_q == sf_q)   state_d = S_IDLE;
        else begin
          state_d   = S_STOP;
          ramp_go_s = 1'b1;
        end
      end
      S_FAULT: begin
        if (fault_clr && !cmd_run) state_d = S_IDLE;
        else                       state_d = S_FAULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: launch latch, ramp moves and the three counters.
  always_comb begin
    freq_d = freq_q;
    sf_d   = sf_q;
    div_d  = div_q;
    wdog_d = wdog_q;
    kick_d = kick_q;
    rev_d  = rev_q;

    if ((state_q == S_IDLE) && (state_d == S_KICK)) begin
      sf_d   = start_freq;
      freq_d = start_freq;
    end else if (ramp_go_s && div_hit_s) begin
      freq_d = step_toward(freq_q, ramp_dst_s);
    end else begin
      freq_d = freq_q;
    end

    // Divider survives RAMP<->STOPPING swaps so a resumed ramp keeps its phase.
    if (ramp_go_s) begin
      if (div_hit_s)  div_d = 6'd0;
      else if (adv_s) div_d = div_q + 6'd1;
      else            div_d = div_q;
    end else if (ramping_q_s && ramping_d_s) begin
      div_d = div_q;
    end else begin
      div_d = 6'd0;
    end

    if (watched_s && watched_d_s) wdog_d = adv_s ? '0 : (wdog_q + 1'b1);
    else                          wdog_d = '0;

    if ((state_q == S_KICK) && (state_d == S_KICK)) kick_d = kick_q + 1'b1;
    else                                            kick_d = '0;

    if ((state_q == S_IDLE) && (state_d == S_KICK)) rev_d = 16'd0;
    else if (wrap_s && (rev_q != 16'hFFFF))         rev_d = rev_q + 16'd1;
    else                                            rev_d = rev_q;
  end

  // State, datapath and output registers, all on the falling edge.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      step_q     <= 4'd0;
      freq_q     <= 10'd0;
      sf_q       <= 10'd0;
      div_q      <= 6'd0;
      wdog_q     <= '0;
      kick_q     <= '0;
      rev_q      <= 16'd0;
      m3start_q  <= 1'b0;
      drive_en_q <= 1'b0;
      at_speed_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= m3step;
      freq_q     <= freq_d;
      sf_q       <= sf_d;
      div_q      <= div_d;
      wdog_q     <= wdog_d;
      kick_q     <= kick_d;
      rev_q      <= rev_d;
      // KICK is only reachable from IDLE, so this pulse is always isolated.
      m3start_q  <= (state_q == S_IDLE) && (state_d == S_KICK);
      drive_en_q <= state_d inside {S_KICK, S_RAMP, S_RUN, S_STOP};
      at_speed_q <= (state_d == S_RUN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign m3start  = m3start_q;
  assign m3freq   = freq_q;
  assign drive_en = drive_en_q;
  assign at_speed = at_speed_q;
  assign fault    = fault_q;
  assign rev_cnt  = rev_q;
  assign state    = state_q;

endmodule
